// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/status stage of an async FIFO: binary/gray write pointer, full, almost-full, fill level, overflow.
// Build option: define WPTR_OVF_STICKY_EN for a sticky woverflow; otherwise woverflow pulses once per dropped write.
module wptr_full_ctrl #(
  parameter int ADDRSIZE  = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                woverflow
);

  localparam int              DEPTH  = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] AF_THR = (ADDRSIZE+1)'(DEPTH - AF_MARGIN);

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] wcount_q, wcount_d;
  logic              wfull_q, wfull_d;
  logic              waf_q, waf_d;
  logic              wovf_q, wovf_d;
  logic [ADDRSIZE:0] rbin;
  logic              accept;

  // Each binary bit is the XOR of all gray bits at or above it; no chained dependency.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++)
      rbin[i] = ^(wq2_rptr >> i);
  end

  assign accept = winc & ~wfull_q;

  always_comb begin
    wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, accept};
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    wcount_d = wbin_d - rbin;
    waf_d    = (wcount_d >= AF_THR);
    // Full when the write pointer is exactly one lap ahead: top two gray bits inverted.
    wfull_d  = (wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
`ifdef WPTR_OVF_STICKY_EN
    wovf_d   = wovf_q | (winc & wfull_q);
`else
    wovf_d   = winc & wfull_q;
`endif
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wcount_q <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wcount_q <= wcount_d;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      wovf_q   <= wovf_d;
    end
  end

  assign wen          = accept;
  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = waf_q;
  assign wcount       = wcount_q;
  assign woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl (ADDRSIZE=4, AF_MARGIN=2); expectations hand-derived per step.
module tb_wptr_full_ctrl;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wcount;
  logic       woverflow;

  int checks = 0;
  int errors = 0;

  wptr_full_ctrl #(.ADDRSIZE(4), .AF_MARGIN(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wcount(wcount), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [4:0] model, prev_ptr, diff;
  logic       ovf_after;

  initial begin
    wrst_n = 1'b0; winc = 1'b1; wq2_rptr = 5'd0;
    step(); step();
    chk("rst_wptr", wptr, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_waf", walmost_full, 0);
    chk("rst_wcount", wcount, 0);
    chk("rst_wovf", woverflow, 0);
    chk("rst_waddr", waddr, 0);

    // Three writes, then an asynchronous mid-burst reset.
    wrst_n = 1'b1;
    step(); step(); step();
    chk("burst_wcount", wcount, 3);
    chk("burst_waddr", waddr, 3);
    chk("burst_wptr", wptr, 5'b00010);
    #2 wrst_n = 1'b0;
    #1;
    chk("async_wptr", wptr, 0);
    chk("async_wcount", wcount, 0);
    chk("async_waddr", waddr, 0);
    step(); step();
    chk("inrst_wptr", wptr, 0);
    chk("inrst_wcount", wcount, 0);
    wrst_n = 1'b1;

    // Fill from empty with read pointer parked at 0.
    for (int n = 1; n <= 16; n++) begin
      step();
      if (n == 13) begin
        chk("f13_wcount", wcount, 13);
        chk("f13_waf", walmost_full, 0);
        chk("f13_wfull", wfull, 0);
      end
      if (n == 14) begin
        chk("f14_waf", walmost_full, 1);
        chk("f14_wcount", wcount, 14);
      end
      if (n == 15) chk("f15_wfull", wfull, 0);
    end
    chk("f16_wfull", wfull, 1);
    chk("f16_wptr", wptr, 5'b11000);
    chk("f16_wcount", wcount, 16);
    chk("f16_waddr", waddr, 0);
    chk("f16_wen", wen, 0);
    chk("f16_wovf", woverflow, 0);

    // Three dropped writes while full.
    for (int n = 0; n < 3; n++) begin
      step();
      chk("ovf_wptr", wptr, 5'b11000);
      chk("ovf_wen", wen, 0);
      chk("ovf_wovf", woverflow, 1);
      chk("ovf_wcount", wcount, 16);
    end
    winc = 1'b0;
    step();
`ifdef WPTR_OVF_STICKY_EN
    ovf_after = 1'b1;
`else
    ovf_after = 1'b0;
`endif
    chk("ovf_after", woverflow, ovf_after);

    // Reader frees one slot: full clears next edge.
    wq2_rptr = 5'b00001;
    step();
    chk("drain_wfull", wfull, 0);
    chk("drain_wcount", wcount, 15);
    chk("drain_waf", walmost_full, 1);
    winc = 1'b1;
    #1;
    chk("drain_wen", wen, 1);
    chk("drain_waddr", waddr, 0);
    step();
    chk("refill_waddr", waddr, 1);
    chk("refill_wcount", wcount, 16);
    chk("refill_wfull", wfull, 1);
    chk("refill_wptr", wptr, 5'b11001);

    // Write while full on the same edge the read pointer advances: dropped, full clears.
    wq2_rptr = 5'b00011;
    step();
    chk("simul_wptr", wptr, 5'b11001);
    chk("simul_waddr", waddr, 1);
    chk("simul_wfull", wfull, 0);
    chk("simul_wcount", wcount, 15);
    chk("simul_wovf", woverflow, 1);

    // Wrap: reader trails the post-write pointer by 3, so fill settles at 3.
    winc = 1'b0;
    wrst_n = 1'b0;
    #1;
    chk("wrap_rst_wovf", woverflow, 0);
    wrst_n = 1'b1;
    model = 5'd0;
    prev_ptr = 5'd0;
    winc = 1'b1;
    for (int n = 0; n < 40; n++) begin
      wq2_rptr = gray(model - 5'd2);
      step();
      model = model + 5'd1;
      diff = wptr ^ prev_ptr;
      chk("wrap_wptr", wptr, gray(model));
      chk("wrap_onebit", $countones(diff), 1);
      chk("wrap_wfull", wfull, 0);
      chk("wrap_wcount", wcount, 3);
      chk("wrap_waddr", waddr, model[3:0]);
      prev_ptr = wptr;
      if (n == 31) chk("wrap_zero", wptr, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
